// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 ROM-sequence writer.
// Holds the FSM state set, special ROM words and default timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR, IDLE, FETCH, SETUP, EHIGH, HOLD, WAIT, DONE
  } lcd_state_e;

  localparam int CNT_W = 24;

  // ROM words that end a sequence without being written
  localparam logic [8:0] TERM_FF = 9'h0FF;
  localparam logic [8:0] TERM_00 = 9'h000;

  // Clear / return-home commands (RS=0) need the long settle time
  localparam logic [8:0] CMD_CLEAR = 9'h001;
  localparam logic [8:0] CMD_HOME  = 9'h002;
  localparam logic [8:0] CMD_HOME2 = 9'h003;

  localparam int DEF_T_PWR   = 750000;
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_E     = 12;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_CMD   = 2000;
  localparam int DEF_T_LONG  = 82000;

  function automatic logic is_term(input logic [8:0] w);
    return (w == TERM_FF) || (w == TERM_00);
  endfunction

  function automatic logic is_long_cmd(input logic [8:0] w);
    return (w == CMD_CLEAR) || (w == CMD_HOME) || (w == CMD_HOME2);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used for every wait in the LCD writer.
// Holds at zero until reloaded; zero flag is combinational from the count.
module lcd_delay_cnt #(
  parameter int          W       = 24,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_rom_writer.sv
// Plays a 9-bit ROM word sequence (RS + byte) onto an HD44780 bus.
// Each state lasting N cycles has the delay counter loaded with N-1 on entry.
module lcd_rom_writer
  import lcd_pkg::*;
#(
  parameter int T_PWR   = DEF_T_PWR,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_E     = DEF_T_E,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_CMD   = DEF_T_CMD,
  parameter int T_LONG  = DEF_T_LONG
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  output logic [6:0] romaddr,
  input  logic [8:0] romq,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB,
  output logic       busy,
  output logic       done,
  output lcd_state_e fsm_state
);

  lcd_state_e       state;
  logic [8:0]       word;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (T_PWR - 1)
  ) u_delay (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (1'b1),
    .zero     (cnt_zero)
  );

  // Reload the counter on the edge that enters the next timed state
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      FETCH: if (!is_term(romq)) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_SETUP - 1);
      end
      SETUP: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_E - 1);
      end
      EHIGH: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_HOLD - 1);
      end
      HOLD: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = is_long_cmd(word) ? CNT_W'(T_LONG - 1) : CNT_W'(T_CMD - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= PWR;
      romaddr <= '0;
      word    <= '0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_DB  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        PWR: if (cnt_zero) state <= IDLE;
        IDLE, DONE: if (start) begin
          romaddr <= '0;
          done    <= 1'b0;
          busy    <= 1'b1;
          state   <= FETCH;
        end
        FETCH: begin
          word <= romq;
          if (is_term(romq)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            LCD_RS <= romq[8];
            LCD_DB <= romq[7:0];
            state  <= SETUP;
          end
        end
        SETUP: if (cnt_zero) begin
          LCD_E <= 1'b1;
          state <= EHIGH;
        end
        EHIGH: if (cnt_zero) begin
          LCD_E <= 1'b0;
          state <= HOLD;
        end
        HOLD: if (cnt_zero) state <= WAIT;
        WAIT: if (cnt_zero) begin
          // The last ROM word ends the sequence instead of wrapping
          if (romaddr == 7'd127) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            romaddr <= romaddr + 7'd1;
            state   <= FETCH;
          end
        end
        default: state <= PWR;
      endcase
    end
  end

  assign LCD_RW    = 1'b0;
  assign fsm_state = state;

endmodule
